change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 190 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
// Greedy coin refund engine with per-denomination coin inventories.
// A refund latches an amount, then repeatedly picks the largest coin
// (5, 2, 1 rupees) that fits the remaining amount and is in stock, and
// offers it to the ejector through a valid/ready handshake.
//
// Ports
//   clk, reset        clock and asynchronous active-high reset
//   start             begin a refund (only honoured while idle)
//   refund_amount     rupees to return, latched on an accepted start
//   restock_valid     add restock_count coins of restock_type this cycle
//   restock_type      denomination code 01=1, 10=2, 11=5, 00=none
//   restock_count     number of coins to add
//   coin_valid        a coin of coin_type is waiting for the ejector
//   coin_type         denomination of the pending coin
//   coin_ready        ejector acknowledge
//   busy              refund in progress
//   done              one-cycle completion pulse
//   error             qualifies done: refund could not be completed
//   remaining         rupees still owed in the current or last refund
//   inv1, inv2, inv5  coin inventory per denomination
module change_dispenser #(
    parameter int AMT_W = 7,
    parameter int INV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] refund_amount,
    input  logic             restock_valid,
    input  logic [1:0]       restock_type,
    input  logic [INV_W-1:0] restock_count,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv1,
    output logic [INV_W-1:0] inv2,
    output logic [INV_W-1:0] inv5
);

    typedef enum logic [1:0] {IDLE, SELECT, EMIT, FINISH} state_t;

    localparam logic [1:0] CODE1 = 2'b01;
    localparam logic [1:0] CODE2 = 2'b10;
    localparam logic [1:0] CODE5 = 2'b11;

    state_t           state;
    state_t           state_next;
    logic [1:0]       pick_type;
    logic             pick_ok;
    logic             fail_q;
    logic             handshake;
    logic [AMT_W-1:0] coin_value;

    assign handshake  = (state == EMIT) && coin_ready;
    assign coin_valid = (state == EMIT);
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign error      = (state == FINISH) && fail_q;

    // Saturating inventory update; the decrement only happens on a
    // handshake, which implies the counter is at least one.
    function automatic logic [INV_W-1:0] next_inv(
        input logic [INV_W-1:0] cur,
        input logic             add_en,
        input logic [INV_W-1:0] add,
        input logic             dec
    );
        logic [INV_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, add} : {(INV_W+1){1'b0}})
              - {{INV_W{1'b0}}, dec};
        if (sum[INV_W]) begin
            return {INV_W{1'b1}};
        end
        return sum[INV_W-1:0];
    endfunction

    // Greedy choice: largest denomination that fits and is in stock.
    always_comb begin
        pick_type = 2'b00;
        pick_ok   = 1'b0;
        if (remaining >= AMT_W'(5) && inv5 != '0) begin
            pick_type = CODE5;
            pick_ok   = 1'b1;
        end else if (remaining >= AMT_W'(2) && inv2 != '0) begin
            pick_type = CODE2;
            pick_ok   = 1'b1;
        end else if (remaining >= AMT_W'(1) && inv1 != '0) begin
            pick_type = CODE1;
            pick_ok   = 1'b1;
        end
    end

    always_comb begin
        coin_value = '0;
        case (coin_type)
            CODE5:   coin_value = AMT_W'(5);
            CODE2:   coin_value = AMT_W'(2);
            CODE1:   coin_value = AMT_W'(1);
            default: coin_value = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (refund_amount != '0) ? SELECT : FINISH;
                end
            end
            SELECT: begin
                if (remaining == '0 || !pick_ok) begin
                    state_next = FINISH;
                end else begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (coin_ready) begin
                    state_next = SELECT;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            coin_type <= 2'b00;
            fail_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= refund_amount;
                        fail_q    <= 1'b0;
                    end
                end
                SELECT: begin
                    if (remaining == '0) begin
                        fail_q <= 1'b0;
                    end else if (pick_ok) begin
                        coin_type <= pick_type;
                    end else begin
                        fail_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (coin_ready) begin
                        remaining <= remaining - coin_value;
                    end
                end
                default: ;
            endcase
        end
    end

    // Restock and handshake decrement may hit the same or different
    // counters in one edge; each counter folds in both independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv1 <= '0;
            inv2 <= '0;
            inv5 <= '0;
        end else begin
            inv1 <= next_inv(inv1, restock_valid && restock_type == CODE1,
                             restock_count, handshake && coin_type == CODE1);
            inv2 <= next_inv(inv2, restock_valid && restock_type == CODE2,
                             restock_count, handshake && coin_type == CODE2);
            inv5 <= next_inv(inv5, restock_valid && restock_type == CODE5,
                             restock_count, handshake && coin_type == CODE5);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Scoreboard bench for change_dispenser: stimulus pushes expected coin
// and completion events, a monitor pops and compares them as the DUT
// presents handshakes and done pulses.
module tb_change_dispenser;

    localparam int AMT_W = 7;
    localparam int INV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AMT_W-1:0] refund_amount;
    logic             restock_valid;
    logic [1:0]       restock_type;
    logic [INV_W-1:0] restock_count;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             coin_ready;
    logic             busy;
    logic             done;
    logic             error;
    logic [AMT_W-1:0] remaining;
    logic [INV_W-1:0] inv1;
    logic [INV_W-1:0] inv2;
    logic [INV_W-1:0] inv5;

    typedef struct {
        bit               is_done;
        logic [1:0]       ctype;
        logic             err;
        logic [AMT_W-1:0] rem;
        logic [INV_W-1:0] i1;
        logic [INV_W-1:0] i2;
        logic [INV_W-1:0] i5;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .refund_amount (refund_amount),
        .restock_valid (restock_valid),
        .restock_type  (restock_type),
        .restock_count (restock_count),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .coin_ready    (coin_ready),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .remaining     (remaining),
        .inv1          (inv1),
        .inv2          (inv2),
        .inv5          (inv5)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_coin(input logic [1:0] t);
        exp_t e;
        e = '{is_done: 1'b0, ctype: t, err: 1'b0, rem: '0, i1: '0, i2: '0, i5: '0};
        sb.push_back(e);
    endtask

    task automatic push_done(input logic err, input logic [AMT_W-1:0] rem,
                             input logic [INV_W-1:0] i1, input logic [INV_W-1:0] i2,
                             input logic [INV_W-1:0] i5);
        exp_t e;
        e = '{is_done: 1'b1, ctype: 2'b00, err: err, rem: rem, i1: i1, i2: i2, i5: i5};
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the restock edge.
    task automatic apply_restock(input logic [1:0] t, input logic [INV_W-1:0] cnt);
        restock_valid = 1'b1;
        restock_type  = t;
        restock_count = cnt;
        @(posedge clk);
        #1;
        restock_valid = 1'b0;
        restock_type  = 2'b00;
        restock_count = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic apply_stimulus(input logic [AMT_W-1:0] amt);
        start         = 1'b1;
        refund_amount = amt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("done_within_budget", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected event per handshake or done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && coin_valid && coin_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_coin: got type %0d expected none", coin_type);
                end else begin
                    e = sb.pop_front();
                    check_output("event_is_coin", {31'd0, e.is_done}, 32'd0);
                    check_output("coin_type", {30'd0, coin_type}, {30'd0, e.ctype});
                end
            end
            if (!reset && done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected none");
                end else begin
                    e = sb.pop_front();
                    check_output("event_is_done", {31'd0, e.is_done}, 32'd1);
                    check_output("done_error", {31'd0, error}, {31'd0, e.err});
                    check_output("done_remaining", {25'd0, remaining}, {25'd0, e.rem});
                    check_output("done_inv1", {24'd0, inv1}, {24'd0, e.i1});
                    check_output("done_inv2", {24'd0, inv2}, {24'd0, e.i2});
                    check_output("done_inv5", {24'd0, inv5}, {24'd0, e.i5});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, "_coin_valid"}, {31'd0, coin_valid}, 32'd0);
        check_output({tag, "_coin_type"}, {30'd0, coin_type}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_done"}, {31'd0, done}, 32'd0);
        check_output({tag, "_error"}, {31'd0, error}, 32'd0);
        check_output({tag, "_remaining"}, {25'd0, remaining}, 32'd0);
        check_output({tag, "_inv1"}, {24'd0, inv1}, 32'd0);
        check_output({tag, "_inv2"}, {24'd0, inv2}, 32'd0);
        check_output({tag, "_inv5"}, {24'd0, inv5}, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        refund_amount = '0;
        restock_valid = 1'b0;
        restock_type  = 2'b00;
        restock_count = '0;
        coin_ready    = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] restock 10 of each coin, type 00 ignored");
        apply_restock(2'b11, 8'd10);
        apply_restock(2'b10, 8'd10);
        apply_restock(2'b01, 8'd10);
        apply_restock(2'b00, 8'd50);
        check_output("restock_inv1", {24'd0, inv1}, 32'd10);
        check_output("restock_inv2", {24'd0, inv2}, 32'd10);
        check_output("restock_inv5", {24'd0, inv5}, 32'd10);

        $display("[TB] refund 8 with ejector stall on first coin");
        push_coin(2'b11);
        push_coin(2'b10);
        push_coin(2'b01);
        push_done(1'b0, 7'd0, 8'd9, 8'd9, 8'd9);
        apply_stimulus(7'd8);
        @(negedge clk);
        check_output("select_busy", {31'd0, busy}, 32'd1);
        check_output("select_no_coin", {31'd0, coin_valid}, 32'd0);
        @(negedge clk);
        check_output("latency_coin_valid", {31'd0, coin_valid}, 32'd1);
        start         = 1'b1;
        refund_amount = 7'd99;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_coin_valid", {31'd0, coin_valid}, 32'd1);
            check_output("stall_coin_type", {30'd0, coin_type}, 32'd3);
            check_output("stall_inv5", {24'd0, inv5}, 32'd10);
            check_output("stall_remaining", {25'd0, remaining}, 32'd8);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        coin_ready = 1'b1;
        wait_done();

        $display("[TB] saturation and coincident restock/handshake");
        apply_restock(2'b01, 8'd241);
        check_output("inv1_250", {24'd0, inv1}, 32'd250);
        apply_restock(2'b01, 8'd10);
        check_output("inv1_saturate", {24'd0, inv1}, 32'd255);
        push_coin(2'b11);
        push_done(1'b0, 7'd0, 8'd255, 8'd9, 8'd9);
        apply_stimulus(7'd5);
        @(negedge clk);
        @(negedge clk);
        restock_valid = 1'b1;
        restock_type  = 2'b11;
        restock_count = 8'd1;
        @(posedge clk);
        #1;
        restock_valid = 1'b0;
        restock_type  = 2'b00;
        restock_count = '0;
        wait_done();

        $display("[TB] reset during EMIT");
        coin_ready = 1'b0;
        apply_stimulus(7'd7);
        @(negedge clk);
        @(negedge clk);
        check_output("pre_reset_coin_valid", {31'd0, coin_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("emit_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] refund 3 with only one 2-rupee coin");
        apply_restock(2'b10, 8'd1);
        coin_ready = 1'b1;
        push_coin(2'b10);
        push_done(1'b1, 7'd1, 8'd0, 8'd0, 8'd3);
        apply_stimulus(7'd3);
        @(negedge clk);
        @(negedge clk);
        restock_valid = 1'b1;
        restock_type  = 2'b11;
        restock_count = 8'd3;
        @(posedge clk);
        #1;
        restock_valid = 1'b0;
        restock_type  = 2'b00;
        restock_count = '0;
        wait_done();

        $display("[TB] refund 0");
        push_done(1'b0, 7'd0, 8'd0, 8'd0, 8'd3);
        apply_stimulus(7'd0);
        @(negedge clk);
        check_output("zero_done", {31'd0, done}, 32'd1);
        check_output("zero_error", {31'd0, error}, 32'd0);
        check_output("zero_no_coin", {31'd0, coin_valid}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] greedy failure on refund 6");
        apply_restock(2'b10, 8'd2);
        push_coin(2'b11);
        push_done(1'b1, 7'd1, 8'd0, 8'd2, 8'd2);
        apply_stimulus(7'd6);
        wait_done();

        @(negedge clk);
        check_output("scoreboard_empty", sb.size(), 32'd0);
        check_output("final_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
